// File: rtl/uart_tx_fifo_if.sv
// Write-side valid/ready handshake for uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular transmit FIFO.
// Frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_fifo_if.slave               wr,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [BW-1:0]        baud;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 par_bit;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic                 tick;
  logic                 frame_end;

  assign empty       = (fifo_count == '0);
  assign wr.wr_ready = (fifo_count != FULL);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign tick        = (baud == BAUD_LAST);
  assign frame_end   = (state == S_STOP) && tick
                       && (bit_idx == STOP_LAST);
  assign pop         = !empty
                       && ((state == S_IDLE) || frame_end);
  assign head        = mem[rd_ptr];
  assign busy        = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      baud <= tick ? '0 : baud + BW'(1);
      unique case (state)
        S_IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
        end
        S_START: begin
          if (tick) begin
            state <= S_DATA;
            tx    <= shift[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PAR;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        S_PAR: begin
          if (tick) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (bit_idx == STOP_LAST) begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
      // A pop (from IDLE or the last stop cycle) overrides the above
      if (pop) begin
        state   <= S_START;
        tx      <= 1'b0;
        shift   <= head;
        par_bit <= (^head) ^ ODD;
        baud    <= '0;
        bit_idx <= '0;
      end
    end
  end
endmodule
